// File: rtl/glitch_seq.sv
// Multi-pulse glitch sequencer.
// Once armed it waits for a start condition (immediate, synchronised trigger
// edge or trigger level), then waits a programmable delay and emits
// cfg_count+1 glitch_en pulses of programmable width, separated by
// programmable gaps. All outputs are registered.
module glitch_seq #(
   parameter int DELAY_W     = 32,
   parameter int WIDTH_W     = 16,
   parameter int COUNT_W     = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [DELAY_W-1:0] cfg_delay,
   input  logic [WIDTH_W-1:0] cfg_width,
   input  logic [WIDTH_W-1:0] cfg_gap,
   input  logic [COUNT_W-1:0] cfg_count,
   input  logic [1:0]         cfg_mode,
   input  logic               arm,
   input  logic               abort,
   input  logic               trig_in,
   output logic               ready,
   output logic               armed,
   output logic               busy,
   output logic               glitch_en,
   output logic [COUNT_W-1:0] pulse_idx,
   output logic               done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_TRIG,
      S_DELAY,
      S_PULSE,
      S_GAP
   } state_t;

   typedef enum logic [1:0] {
      M_IMMEDIATE = 2'b00,
      M_RISE      = 2'b01,
      M_FALL      = 2'b10,
      M_LEVEL     = 2'b11
   } mode_t;

   localparam logic [DELAY_W-1:0] D_ONE = DELAY_W'(1);
   localparam logic [WIDTH_W-1:0] W_ONE = WIDTH_W'(1);
   localparam logic [COUNT_W-1:0] C_ONE = COUNT_W'(1);

   // Sequencer state and counters
   state_t               r_state;
   logic [DELAY_W-1:0]   r_dcnt;
   logic [WIDTH_W-1:0]   r_pcnt;
   logic [COUNT_W-1:0]   r_idx;

   // Registered outputs
   logic                 r_ready;
   logic                 r_armed;
   logic                 r_busy;
   logic                 r_glitch;
   logic                 r_done;

   // Configuration captured at arm time
   logic [DELAY_W-1:0]   r_lat_delay;
   logic [WIDTH_W-1:0]   r_lat_width;
   logic [WIDTH_W-1:0]   r_lat_gap;
   logic [COUNT_W-1:0]   r_lat_count;
   mode_t                r_lat_mode;

   // Trigger synchroniser and edge detector
   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_s_prev;
   logic                   w_s;
   logic                   w_trig_hit;

   // Next-state values
   state_t               w_state_nxt;
   logic [DELAY_W-1:0]   w_dcnt_nxt;
   logic [WIDTH_W-1:0]   w_pcnt_nxt;
   logic [COUNT_W-1:0]   w_idx_nxt;
   logic                 w_done_nxt;
   logic                 w_load;

   assign w_s = r_sync[SYNC_STAGES-1];

   // Bring trig_in into the clk domain and keep the previous synchronised value
   always_ff @(posedge clk) begin
      // NOTE: sequential state always uses non-blocking assignments so every
      // flop samples pre-edge values regardless of statement order.
      if (rst) begin
         r_sync   <= '0;
         r_s_prev <= 1'b0;
      end else begin
         r_sync   <= {r_sync[SYNC_STAGES-2:0], trig_in};
         r_s_prev <= w_s;
      end
   end

   // Select the start condition for the latched mode
   always_comb begin
      w_trig_hit = 1'b0;
      unique case (r_lat_mode)
         M_RISE:  w_trig_hit = w_s & ~r_s_prev;
         M_FALL:  w_trig_hit = ~w_s & r_s_prev;
         M_LEVEL: w_trig_hit = w_s;
         default: w_trig_hit = 1'b0;
      endcase
   end

   // Capture the programmed sequence when an arm is accepted
   always_ff @(posedge clk) begin
      // NOTE: these are plain data registers; they are only read after being
      // loaded at arm time, so they carry no reset.
      if (w_load) begin
         r_lat_delay <= cfg_delay;
         r_lat_width <= cfg_width;
         r_lat_gap   <= cfg_gap;
         r_lat_count <= cfg_count;
         r_lat_mode  <= mode_t'(cfg_mode);
      end
   end

   // Next-state, counter and pulse-index logic; abort overrides everything
   always_comb begin
      // NOTE: every signal gets a default first so no path infers a latch.
      w_state_nxt = r_state;
      w_dcnt_nxt  = r_dcnt;
      w_pcnt_nxt  = r_pcnt;
      w_idx_nxt   = r_idx;
      w_done_nxt  = 1'b0;
      w_load      = 1'b0;

      if (abort) begin
         w_state_nxt = S_IDLE;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (arm) begin
                  w_load      = 1'b1;
                  w_dcnt_nxt  = '0;
                  w_pcnt_nxt  = '0;
                  w_idx_nxt   = '0;
                  w_state_nxt = (mode_t'(cfg_mode) == M_IMMEDIATE) ? S_DELAY : S_WAIT_TRIG;
               end
            end
            S_WAIT_TRIG: begin
               if (w_trig_hit) begin
                  w_state_nxt = S_DELAY;
                  w_dcnt_nxt  = '0;
               end
            end
            S_DELAY: begin
               if (r_dcnt == r_lat_delay) begin
                  w_state_nxt = S_PULSE;
                  w_pcnt_nxt  = '0;
               end else begin
                  w_dcnt_nxt  = r_dcnt + D_ONE;
               end
            end
            S_PULSE: begin
               if (r_pcnt == r_lat_width) begin
                  w_pcnt_nxt = '0;
                  if (r_idx == r_lat_count) begin
                     w_state_nxt = S_IDLE;
                     w_done_nxt  = 1'b1;
                  end else begin
                     w_state_nxt = S_GAP;
                  end
               end else begin
                  w_pcnt_nxt = r_pcnt + W_ONE;
               end
            end
            S_GAP: begin
               if (r_pcnt == r_lat_gap) begin
                  w_state_nxt = S_PULSE;
                  w_pcnt_nxt  = '0;
                  w_idx_nxt   = r_idx + C_ONE;
               end else begin
                  w_pcnt_nxt  = r_pcnt + W_ONE;
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   // State register; status outputs are registered copies of the next state
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_dcnt   <= '0;
         r_pcnt   <= '0;
         r_idx    <= '0;
         r_ready  <= 1'b1;
         r_armed  <= 1'b0;
         r_busy   <= 1'b0;
         r_glitch <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_dcnt   <= w_dcnt_nxt;
         r_pcnt   <= w_pcnt_nxt;
         r_idx    <= w_idx_nxt;
         r_ready  <= (w_state_nxt == S_IDLE);
         r_armed  <= (w_state_nxt == S_WAIT_TRIG);
         r_busy   <= (w_state_nxt == S_DELAY) || (w_state_nxt == S_PULSE) ||
                     (w_state_nxt == S_GAP);
         r_glitch <= (w_state_nxt == S_PULSE);
         r_done   <= w_done_nxt;
      end
   end

   assign ready     = r_ready;
   assign armed     = r_armed;
   assign busy      = r_busy;
   assign glitch_en = r_glitch;
   assign pulse_idx = r_idx;
   assign done      = r_done;

endmodule

// File: tb/tb_glitch_seq.sv
// Self-checking bench for glitch_seq: directed steps, with the expected
// per-cycle output trace queued when a sequence is started and compared
// cycle by cycle as the DUT runs it.
module tb_glitch_seq;

   localparam int DELAY_W     = 32;
   localparam int WIDTH_W     = 16;
   localparam int COUNT_W     = 8;
   localparam int SYNC_STAGES = 2;

   logic               clk;
   logic               rst;
   logic [DELAY_W-1:0] cfg_delay;
   logic [WIDTH_W-1:0] cfg_width;
   logic [WIDTH_W-1:0] cfg_gap;
   logic [COUNT_W-1:0] cfg_count;
   logic [1:0]         cfg_mode;
   logic               arm;
   logic               abort;
   logic               trig_in;
   logic               ready;
   logic               armed;
   logic               busy;
   logic               glitch_en;
   logic [COUNT_W-1:0] pulse_idx;
   logic               done;

   glitch_seq #(
      .DELAY_W     (DELAY_W),
      .WIDTH_W     (WIDTH_W),
      .COUNT_W     (COUNT_W),
      .SYNC_STAGES (SYNC_STAGES)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cfg_delay (cfg_delay),
      .cfg_width (cfg_width),
      .cfg_gap   (cfg_gap),
      .cfg_count (cfg_count),
      .cfg_mode  (cfg_mode),
      .arm       (arm),
      .abort     (abort),
      .trig_in   (trig_in),
      .ready     (ready),
      .armed     (armed),
      .busy      (busy),
      .glitch_en (glitch_en),
      .pulse_idx (pulse_idx),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected outputs after one clock edge
   typedef struct packed {
      logic               glitch;
      logic               done;
      logic               busy;
      logic               armed;
      logic [COUNT_W-1:0] idx;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_err    = 0;
   int   high_cnt = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_e(input logic g, input logic d, input logic b, input logic a, input int idx);
      exp_t e;
      e.glitch = g;
      e.done   = d;
      e.busy   = b;
      e.armed  = a;
      e.idx    = COUNT_W'(idx);
      exp_q.push_back(e);
   endtask

   // Expected trace: wait_n cycles armed, lead_n cycles of delay, then
   // c+1 pulses of w+1 high cycles with g+1 low cycles between, then done.
   task automatic push_seq(input int wait_n, input int lead_n, input int w, input int g, input int c);
      for (int i = 0; i < wait_n; i++) push_e(1'b0, 1'b0, 1'b0, 1'b1, 0);
      for (int i = 0; i < lead_n; i++) push_e(1'b0, 1'b0, 1'b1, 1'b0, 0);
      for (int p = 0; p <= c; p++) begin
         for (int i = 0; i <= w; i++) push_e(1'b1, 1'b0, 1'b1, 1'b0, p);
         if (p < c)
            for (int i = 0; i <= g; i++) push_e(1'b0, 1'b0, 1'b1, 1'b0, p);
      end
      push_e(1'b0, 1'b1, 1'b0, 1'b0, c);
   endtask

   task automatic drain_n(input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         if (exp_q.size() == 0) break;
         @(negedge clk);
         e = exp_q.pop_front();
         check("glitch_en", 32'(glitch_en), 32'(e.glitch));
         check("done",      32'(done),      32'(e.done));
         check("busy",      32'(busy),      32'(e.busy));
         check("armed",     32'(armed),     32'(e.armed));
         check("pulse_idx", 32'(pulse_idx), 32'(e.idx));
         if (glitch_en) high_cnt++;
      end
   endtask

   task automatic drain_all();
      drain_n(exp_q.size());
   endtask

   // Program the configuration and present arm for one edge
   task automatic arm_seq(input int d, input int w, input int g, input int c, input logic [1:0] mode);
      cfg_delay = DELAY_W'(d);
      cfg_width = WIDTH_W'(w);
      cfg_gap   = WIDTH_W'(g);
      cfg_count = COUNT_W'(c);
      cfg_mode  = mode;
      arm       = 1'b1;
      @(negedge clk);
      arm       = 1'b0;
   endtask

   // Watchdog so the run always ends
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; arm = 1'b0; abort = 1'b0; trig_in = 1'b0;
      cfg_delay = '0; cfg_width = '0; cfg_gap = '0; cfg_count = '0; cfg_mode = 2'b00;
      repeat (3) @(negedge clk);
      check("rst_ready",  32'(ready),     1);
      check("rst_armed",  32'(armed),     0);
      check("rst_busy",   32'(busy),      0);
      check("rst_glitch", 32'(glitch_en), 0);
      check("rst_done",   32'(done),      0);
      check("rst_idx",    32'(pulse_idx), 0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_ready", 32'(ready), 1);

      // Immediate, D=3 W=1 C=0: high on edges k+4..k+5, done at k+6
      arm_seq(3, 1, 0, 0, 2'b00);
      check("t1_ready0", 32'(ready), 0);
      check("t1_busy",   32'(busy),  1);
      push_seq(0, 3, 1, 0, 0);
      high_cnt = 0;
      drain_all();
      check("t1_high",  high_cnt, 2);
      check("t1_ready", 32'(ready), 1);

      // Immediate, D=0 W=2 G=1 C=2: three 3-cycle pulses, 2-cycle gaps
      arm_seq(0, 2, 1, 2, 2'b00);
      push_seq(0, 0, 2, 1, 2);
      high_cnt = 0;
      drain_all();
      check("t2_high",  high_cnt, 9);
      check("t2_ready", 32'(ready), 1);

      // arm and abort together in IDLE: abort wins
      cfg_mode = 2'b00;
      arm = 1'b1; abort = 1'b1;
      @(negedge clk);
      arm = 1'b0; abort = 1'b0;
      check("armabort_ready", 32'(ready), 1);
      check("armabort_busy",  32'(busy),  0);
      check("armabort_armed", 32'(armed), 0);

      // Rising-edge mode, D=5 W=0: high only for the cycle after edge j+8
      arm_seq(5, 0, 0, 0, 2'b01);
      check("t3_armed", 32'(armed), 1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t3_wait_armed",  32'(armed),     1);
         check("t3_wait_glitch", 32'(glitch_en), 0);
      end
      trig_in = 1'b1;
      @(negedge clk);
      check("t3_armed_j", 32'(armed), 1);
      push_seq(SYNC_STAGES - 1, 6, 0, 0, 0);
      high_cnt = 0;
      drain_all();
      check("t3_high", high_cnt, 1);
      trig_in = 1'b0;
      repeat (4) @(negedge clk);
      check("t3_no_retrig", 32'(busy), 0);

      // Falling-edge mode with trig_in held high: waits for the 1->0 edge
      trig_in = 1'b1;
      repeat (4) @(negedge clk);
      arm_seq(1, 0, 0, 0, 2'b10);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("t4_hold_armed",  32'(armed),     1);
         check("t4_hold_glitch", 32'(glitch_en), 0);
      end
      trig_in = 1'b0;
      @(negedge clk);
      push_seq(SYNC_STAGES - 1, 2, 0, 0, 0);
      high_cnt = 0;
      drain_all();
      check("t4_high", high_cnt, 1);

      // Level mode with trig_in already high: DELAY one edge after WAIT_TRIG
      trig_in = 1'b1;
      repeat (4) @(negedge clk);
      arm_seq(2, 1, 0, 0, 2'b11);
      check("t5_armed", 32'(armed), 1);
      check("t5_busy",  32'(busy),  0);
      push_seq(0, 3, 1, 0, 0);
      high_cnt = 0;
      drain_all();
      check("t5_high", high_cnt, 2);
      trig_in = 1'b0;
      repeat (4) @(negedge clk);

      // Abort during pulse 1 of C=3
      arm_seq(1, 3, 1, 3, 2'b00);
      push_seq(0, 1, 3, 1, 3);
      drain_n(9);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      exp_q.delete();
      check("t6_glitch", 32'(glitch_en), 0);
      check("t6_ready",  32'(ready),     1);
      check("t6_busy",   32'(busy),      0);
      check("t6_armed",  32'(armed),     0);
      check("t6_done",   32'(done),      0);
      check("t6_idx",    32'(pulse_idx), 1);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("t6_after_done",   32'(done),      0);
         check("t6_after_glitch", 32'(glitch_en), 0);
      end
      arm_seq(0, 0, 0, 0, 2'b00);
      push_seq(0, 0, 0, 0, 0);
      high_cnt = 0;
      drain_all();
      check("t6_rearm_high", high_cnt, 1);

      // cfg change and arm held while busy: latched widths, no restart
      arm_seq(1, 2, 0, 1, 2'b00);
      cfg_width = WIDTH_W'(7);
      cfg_delay = DELAY_W'(0);
      cfg_count = COUNT_W'(5);
      arm = 1'b1;
      push_seq(0, 1, 2, 0, 1);
      high_cnt = 0;
      drain_n(4);
      arm = 1'b0;
      drain_all();
      check("t7_high",  high_cnt, 6);
      check("t7_ready", 32'(ready), 1);
      @(negedge clk);
      check("t7_no_restart_busy",   32'(busy),      0);
      check("t7_no_restart_glitch", 32'(glitch_en), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/glitch_seq.md
Name: glitch_seq

Overview:
- Parametrised multi-pulse glitch sequencer; successor to the single-shot delay/width glitcher.
- Once armed, it waits for a start condition: immediate, synchronised external trigger edge, or trigger level.
- It then waits a programmable delay and emits a train of cfg_count+1 glitch_en pulses, each of programmable width, separated by programmable gaps.
- glitch_en drives the downstream clock-XOR or crowbar injector; the host control interface programs the cfg_* inputs and reads status.

Parameters:
- DELAY_W, 32, width of cfg_delay and the delay counter
- WIDTH_W, 16, width of cfg_width, cfg_gap and the shared pulse/gap counter
- COUNT_W, 8, width of cfg_count and pulse_idx
- SYNC_STAGES, 2, flops in the trig_in synchroniser (minimum 2)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- cfg_delay  in  DELAY_W  delay value D; delay lasts D+1 cycles
- cfg_width  in  WIDTH_W  width value W; each pulse lasts W+1 cycles
- cfg_gap  in  WIDTH_W  gap value G; each inter-pulse gap lasts G+1 cycles
- cfg_count  in  COUNT_W  pulse count value C; C+1 pulses are emitted
- cfg_mode  in  2  start mode: 00 immediate, 01 trig rising edge, 10 trig falling edge, 11 trig high level
- arm  in  1  start request; sampled only while ready=1
- abort  in  1  cancel; takes effect in any state
- trig_in  in  1  asynchronous external trigger
- ready  out  1  idle; a new arm is accepted
- armed  out  1  in WAIT_TRIG state
- busy  out  1  in DELAY, PULSE or GAP state
- glitch_en  out  1  glitch pulse output, registered
- pulse_idx  out  COUNT_W  index of the current or most recent pulse, starting at 0
- done  out  1  one-cycle strobe when a sequence completes normally

Behaviour:
- Reset values: ready=1; armed, busy, glitch_en and done = 0; pulse_idx=0; state=IDLE; synchroniser and edge flops = 0.
- All outputs are registered.
- States: IDLE, WAIT_TRIG, DELAY, PULSE, GAP.
- IDLE: arm=1 at an edge latches all cfg_* inputs. cfg_* changes after that edge have no effect on the running sequence. At the same edge: ready<=0, counters<=0, pulse_idx<=0. Next state is DELAY when cfg_mode=00, otherwise WAIT_TRIG.
- Trigger detection: trig_in passes through SYNC_STAGES flops to give s, plus one flop holding s_prev.
  - rise = s & ~s_prev
  - fall = ~s & s_prev
  - level = s
- WAIT_TRIG: armed=1. When the selected trigger condition is true at an edge, next state is DELAY and the counter is cleared. A trigger condition that is already present when entering WAIT_TRIG still counts only if it holds on a clock edge while in WAIT_TRIG: edge modes need a fresh edge, level mode fires immediately.
- DELAY: the counter increments each cycle. At the edge where count==D, next state is PULSE, glitch_en<=1 and the counter is cleared.
- PULSE: the counter increments. At the edge where count==W, glitch_en<=0 and the counter is cleared.
  - If pulse_idx==C: next state is IDLE, ready<=1, done<=1 for exactly one cycle. pulse_idx holds C.
  - Otherwise: next state is GAP.
- GAP: the counter increments. At the edge where count==G: next state is PULSE, glitch_en<=1, pulse_idx<=pulse_idx+1, counter cleared.
- Timing, immediate mode: arm sampled at edge k.
  - Pulse 0 glitch_en rises at edge k+D+1 and stays high W+1 cycles.
  - Each gap is exactly G+1 low cycles.
  - Total high cycles = (C+1)(W+1).
- Timing, trigger modes: with trig_in stable before edge j, glitch_en rises at edge j+SYNC_STAGES+D+1. This latency is fixed and deterministic.
- Boundary: D=0 rises at the next edge. W=0 gives a single-cycle pulse. G=0 gives a single-cycle gap. Maximum values wrap nowhere, because counters compare for equality and never exceed the latched value.
- Abort has priority over arm and over all transitions. At the edge where abort=1:
  - state<=IDLE, glitch_en<=0, ready<=1
  - armed<=0, busy<=0, done stays 0, pulse_idx holds its value
- arm while ready=0 is ignored; it neither queues nor restarts the sequence.
- arm and abort together in IDLE: abort wins and the block stays IDLE.
- Triggers arriving during DELAY, PULSE or GAP are ignored; there is no retrigger.
- rst mid-sequence behaves as abort and additionally applies the full reset values.

Test Plan:
- Immediate, D=3, W=1, C=0: arm at edge k -> glitch_en high for edges k+4..k+5 only; done=1 at edge k+6; ready=1.
- Immediate, D=0, W=2, G=1, C=2 -> three 3-cycle pulses separated by 2-cycle gaps; pulse_idx 0,1,2; 9 high cycles total; one done strobe.
- Rising-edge mode, SYNC_STAGES=2, D=5, W=0: trig_in rises before edge j -> glitch_en high for the single cycle after edge j+8; armed=1 until edge j+2.
- Falling-edge mode with trig_in held high, then level mode with trig_in high at arm -> falling mode waits for the 1->0 transition; level mode enters DELAY one edge after entering WAIT_TRIG.
- Abort during pulse 1 of C=3 -> glitch_en=0 and ready=1 at the next edge; done never asserts; a new arm is then accepted normally.
- Change cfg_width during a sequence, and arm pulsed while busy -> the running pulse widths keep the latched value; no restart occurs.
